serie_shift_sequencer: RTL and testbench
========================================

# serie_shift_sequencer

Sequencer and two-requester arbiter for the shared 4-bit bidirectional serial shift register. It accepts a 4-bit word from one of two requesters and drives the register's Ena/LeRi/Data_In for four load shifts. It then runs four unload shifts, sampling the register's serial output to rebuild the word on Result. It sits between the parallel requesters and the serial register and is the only block that drives the register's control inputs.

## Interface
Parameters:
- NBITS, 4, width of a transfer; must equal the shift register depth.

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-low; also wired to the shift register's Rst
- Req  in  2  per-requester transfer request, level, held until matching Gnt
- Dir  in  2  per-requester direction; 1 = left shift (LeRi=1), 0 = right shift
- Word0  in  NBITS  requester 0 data
- Word1  in  NBITS  requester 1 data
- Gnt  out  2  one-hot one-cycle grant pulse; word and dir captured on the edge that raises it
- Busy  out  1  high from grant edge until the Done edge
- Done  out  1  one-cycle pulse; Result and Done_Id valid while high
- Done_Id  out  1  index of the requester whose transfer completed
- Result  out  NBITS  word reconstructed from the register's serial output; held until next Done
- Reg_Data_In  out  1  to shift register Data_In
- Reg_Ena  out  1  to shift register Ena
- Reg_LeRi  out  1  to shift register LeRi
- Reg_Data_Out  in  1  from shift register Data_Out

## Operation
- States: IDLE, LOAD, UNLOAD. A 2-bit bit counter, cnt, is used in LOAD and UNLOAD.
- IDLE:
  - Reg_Ena=0, Reg_LeRi=0, Reg_Data_In=0.
  - If any Req is high at an edge, the arbiter picks a winner.
  - On that edge: Gnt[w]=1, Busy=1, the winner's word is captured to shreg and its Dir bit to dir, cnt=0, next state LOAD.
- LOAD (4 cycles):
  - Reg_Ena=1, Reg_LeRi=dir.
  - Reg_Data_In is shreg[3-cnt] when dir=1 (MSB first) and shreg[cnt] when dir=0 (LSB first), so the register holds the word after the 4th shift.
  - cnt increments each edge; after cnt=3 the next state is UNLOAD with cnt=0.
- UNLOAD (4 cycles):
  - Reg_Ena=1, Reg_LeRi=dir, Reg_Data_In=0, so the register drains to zero.
  - Each edge samples Reg_Data_Out into Result: bit 3-cnt when dir=1, bit cnt when dir=0.
  - On the cnt=3 edge: Done=1, Done_Id=winner, Busy=0, next state IDLE.
- Gnt and Done are single-cycle pulses and are cleared on the following edge.
- Req, Dir and Word changes after the grant edge are ignored for the current transfer.
- Req asserted while Busy is held pending and arbitrated on the first IDLE edge.
- Arbitration is round-robin when SERIE_ARB_RR_EN is defined (see Configuration).

## Timing
- Reset (Rst low, asynchronous):
  - State IDLE, cnt=0, all outputs 0, Result=0, RR pointer favours requester 0.
  - The shift register is cleared by the same reset.
  - Reset mid-transfer aborts the transfer with no Done.
- Latency for grant at edge E0:
  - Load shifts occur at E1..E4; unload samples at E5..E8.
  - Done is high for the cycle after E8. The next grant can occur at E9 at the earliest.
  - Throughput is one transfer per 9 cycles.
- Control outputs are decoded from registered state and counter only; there is no combinational path from Req to Reg_*.
- Reg_Data_Out is combinational in the register and is sampled at the same edge that performs the shift.

## Configuration
- SERIE_ARB_RR_EN defined:
  - Round-robin arbitration; after a grant to requester n, requester 1-n has priority on the next contention.
  - The pointer updates only on a grant edge.
- Undefined: fixed priority, requester 0 always wins. Requester 1 may starve; this is permitted.

## Structure
- Shared package serie_pkg holds:
  - the state enum (IDLE, LOAD, UNLOAD);
  - the NBITS default constant;
  - the DIR_LEFT=1 and DIR_RIGHT=0 constants.
- Sub-module serie_rr_arbiter:
  - Inputs: Req[1:0], plus an advance signal from the FSM.
  - Output: one-hot grant.
  - Contains the priority pointer; the fixed-priority variant is selected by the macro.

## Test plan
- Reset mid-LOAD: assert Req[0], Word0=4'b1011, Dir0=1, then pull Rst low at E2 -> all outputs 0 immediately, no Done, a new request is granted normally.
- Single left transfer: Req[0], Word0=4'b1011, Dir0=1 -> Gnt=01 at E0; Reg_Data_In sequence 1,0,1,1 at E1..E4; Done with Result=1011 and Done_Id=0 after E8.
- Single right transfer: Req[1], Word1=4'b0110, Dir1=0 -> Reg_Data_In sequence 0,1,1,0; Result=0110, Done_Id=1.
- Contention with RR: both Req high continuously, Word0=0001, Word1=1000 -> grants alternate 01,10,01; with the macro undefined, only 01.
- Request while busy: Req[1] raised at E3 of a requester-0 transfer -> Gnt=10 at E9, exactly one cycle after Done.
- Register drain check: after Done, the shift register's Data_Out is 0 in both directions and Reg_Ena is 0 while IDLE.

Source files
------------

// File: rtl/serie_pkg.sv
// serie_pkg: shared state encoding, width and direction constants for the serial shift sequencer
package serie_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;
  localparam int SERIE_NBITS = 4;
  localparam logic DIR_LEFT = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
endpackage

// File: rtl/serie_rr_arbiter.sv
// serie_rr_arbiter: two-requester arbiter; round-robin when SERIE_ARB_RR_EN is defined, fixed priority to requester 0 otherwise
module serie_rr_arbiter (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);
  logic r_ptr;
  // Priority pointer (1 = requester 1 wins a tie), moved only when a grant is taken
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) r_ptr <= 1'b0;
`ifdef SERIE_ARB_RR_EN
    else if (i_adv) r_ptr <= o_gnt[0];
`else
    else if (i_adv) r_ptr <= 1'b0;
`endif
  // One-hot winner among the current requests, favouring the pointed-to requester
  always_comb
    o_gnt = ((r_ptr || !i_req[0]) && i_req[1]) ? 2'b10 : {1'b0, i_req[0]};
endmodule

// File: rtl/serie_shift_sequencer.sv
// serie_shift_sequencer: arbitrated load/unload sequencer for the shared serial shift register (SERIE_ARB_RR_EN selects round-robin arbitration)
module serie_shift_sequencer
  import serie_pkg::*;
#(
  parameter int NBITS = SERIE_NBITS
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Req,
  input  logic [1:0]       Dir,
  input  logic [NBITS-1:0] Word0,
  input  logic [NBITS-1:0] Word1,
  output logic [1:0]       Gnt,
  output logic             Busy,
  output logic             Done,
  output logic             Done_Id,
  output logic [NBITS-1:0] Result,
  output logic             Reg_Data_In,
  output logic             Reg_Ena,
  output logic             Reg_LeRi,
  input  logic             Reg_Data_Out
);
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_idx;
  logic [NBITS-1:0] r_shreg, r_acc, r_result, w_acc_nxt;
  logic [1:0] r_gnt, w_gnt;
  logic r_dir, r_id, r_busy, r_done, r_done_id, w_take, w_last;
  assign w_take = (r_state == IDLE) && |Req;
  serie_rr_arbiter u_arb (.Clk, .Rst, .i_req(Req), .i_adv(w_take), .o_gnt(w_gnt));
  // State register
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // Next state and register controls, decoded from registered state and counter only
  always_comb begin
    w_idx = (r_dir == DIR_LEFT) ? LAST - r_cnt : r_cnt;
    w_last = r_cnt == LAST;
    w_acc_nxt = r_acc;
    w_acc_nxt[w_idx] = Reg_Data_Out;
    Reg_Ena = r_state != IDLE;
    Reg_LeRi = Reg_Ena && r_dir;
    Reg_Data_In = (r_state == LOAD) && r_shreg[w_idx];
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_take ? LOAD : IDLE;
      LOAD:    w_state_nxt = w_last ? UNLOAD : LOAD;
      UNLOAD:  w_state_nxt = w_last ? IDLE : UNLOAD;
      default: w_state_nxt = IDLE;
    endcase
  end
  // Datapath: capture winner on grant, count shifts, rebuild the word, pulse Gnt/Done
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      r_cnt <= '0;
      r_shreg <= '0;
      r_acc <= '0;
      r_result <= '0;
      r_gnt <= 2'b00;
      r_dir <= 1'b0;
      r_id <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_gnt <= w_take ? w_gnt : 2'b00;
      r_done <= (r_state == UNLOAD) && w_last;
      r_cnt <= (r_state == IDLE) ? '0 : r_cnt + 1'b1;
      if (w_take) begin
        r_shreg <= w_gnt[1] ? Word1 : Word0;
        r_dir <= Dir[w_gnt[1]];
        r_id <= w_gnt[1];
        r_busy <= 1'b1;
      end
      if (r_state == UNLOAD) r_acc <= w_acc_nxt;
      if (r_state == UNLOAD && w_last) begin
        r_result <= w_acc_nxt;
        r_done_id <= r_id;
        r_busy <= 1'b0;
      end
    end
  assign Gnt = r_gnt;
  assign Busy = r_busy;
  assign Done = r_done;
  assign Done_Id = r_done_id;
  assign Result = r_result;
endmodule

// File: tb/tb_serie_shift_sequencer.sv
// tb_serie_shift_sequencer: directed bench with a behavioural 4-bit bidirectional shift register on the serial side
module tb_serie_shift_sequencer;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic [1:0] Req = 2'b00;
  logic [1:0] Dir = 2'b00;
  logic [3:0] Word0 = 4'b0000;
  logic [3:0] Word1 = 4'b0000;
  logic [1:0] Gnt;
  logic Busy, Done, Done_Id, Reg_Data_In, Reg_Ena, Reg_LeRi, Reg_Data_Out;
  logic [3:0] Result, q;
  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  serie_shift_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Dir(Dir), .Word0(Word0), .Word1(Word1),
    .Gnt(Gnt), .Busy(Busy), .Done(Done), .Done_Id(Done_Id), .Result(Result),
    .Reg_Data_In(Reg_Data_In), .Reg_Ena(Reg_Ena), .Reg_LeRi(Reg_LeRi), .Reg_Data_Out(Reg_Data_Out)
  );

  // Shared serial register: LeRi=1 shifts toward MSB, LeRi=0 toward LSB, output is the bit leaving
  always @(posedge Clk or negedge Rst)
    if (!Rst) q <= 4'b0000;
    else if (Reg_Ena) q <= Reg_LeRi ? {q[2:0], Reg_Data_In} : {Reg_Data_In, q[3:1]};
  assign Reg_Data_Out = Reg_LeRi ? q[3] : q[0];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({Gnt, Busy, Done, Done_Id, Result, Reg_Data_In, Reg_Ena, Reg_LeRi} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 0", {Gnt, Busy, Done, Done_Id, Result, Reg_Data_In, Reg_Ena, Reg_LeRi});
    end
    tick;
    tick;
    Rst = 1'b1;
    tick;
    n_checks++;
    if ({Gnt, Reg_Ena, Busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b exp 0", {Gnt, Reg_Ena, Busy});
    end
  endtask

  task automatic test_single(input logic id, input logic d, input logic [3:0] w, input logic [0:3] seq);
    logic [3:0] ctl;
    Req = id ? 2'b10 : 2'b01;
    Dir = {d, d};
    if (id) Word1 = w; else Word0 = w;
    tick;
    Req = 2'b00;
    n_checks++;
    if ({Gnt, Busy} !== {(id ? 2'b10 : 2'b01), 1'b1}) begin
      n_fail++;
      $display("FAIL grant_%0d got gnt=%b busy=%b exp gnt=%b busy=1", id, Gnt, Busy, id ? 2'b10 : 2'b01);
    end
    for (int k = 0; k < 8; k++) begin
      ctl = {1'b1, d, (k < 4) ? seq[k] : 1'b0, 1'b0};
      n_checks++;
      if ({Reg_Ena, Reg_LeRi, Reg_Data_In, Done} !== ctl) begin
        n_fail++;
        $display("FAIL shift_%0d_cycle%0d ena/leri/din/done got %b exp %b", id, k, {Reg_Ena, Reg_LeRi, Reg_Data_In, Done}, ctl);
      end
      tick;
    end
    n_checks++;
    if ({Done, Done_Id, Result, Busy} !== {1'b1, id, w, 1'b0}) begin
      n_fail++;
      $display("FAIL done_%0d got done=%b id=%b res=%b busy=%b exp 1 %b %b 0", id, Done, Done_Id, Result, Busy, id, w);
    end
    tick;
    n_checks++;
    if ({Done, Reg_Ena, q, Reg_Data_Out, Result} !== {6'b0, w}) begin
      n_fail++;
      $display("FAIL drain_%0d got done=%b ena=%b q=%b dout=%b res=%b exp 0 0 0000 0 %b", id, Done, Reg_Ena, q, Reg_Data_Out, Result, w);
    end
  endtask

  task automatic test_contention;
    logic [1:0] eg [3];
`ifdef SERIE_ARB_RR_EN
    eg = '{2'b01, 2'b10, 2'b01};
`else
    eg = '{2'b01, 2'b01, 2'b01};
`endif
    Word0 = 4'b0001;
    Word1 = 4'b1000;
    Dir = 2'b00;
    Req = 2'b11;
    for (int c = 0; c < 27; c++) begin
      tick;
      if (c == 18) Req = 2'b00;
      if (c % 9 == 0) begin
        n_checks++;
        if (Gnt !== eg[c/9]) begin
          n_fail++;
          $display("FAIL contention_grant%0d got %b exp %b", c/9, Gnt, eg[c/9]);
        end
      end
      if (c % 9 == 8) begin
        n_checks++;
        if ({Done, Done_Id, Result} !== {1'b1, eg[c/9][1], (eg[c/9][1] ? 4'b1000 : 4'b0001)}) begin
          n_fail++;
          $display("FAIL contention_done%0d got done=%b id=%b res=%b exp id=%b", c/9, Done, Done_Id, Result, eg[c/9][1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    Word0 = 4'b1011;
    Word1 = 4'b0101;
    Dir = 2'b11;
    Req = 2'b01;
    tick;
    Req = 2'b00;
    n_checks++;
    if (Gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_first_grant got %b exp 01", Gnt);
    end
    tick;
    tick;
    Req = 2'b10;
    for (int k = 0; k < 6; k++) tick;
    n_checks++;
    if ({Done, Done_Id, Result, Gnt, Busy} !== {1'b1, 1'b0, 4'b1011, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL busy_first_done got done=%b id=%b res=%b gnt=%b busy=%b exp 1 0 1011 00 0", Done, Done_Id, Result, Gnt, Busy);
    end
    tick;
    Req = 2'b00;
    n_checks++;
    if ({Gnt, Busy, Done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL pending_grant got gnt=%b busy=%b done=%b exp 10 1 0", Gnt, Busy, Done);
    end
    for (int k = 0; k < 8; k++) tick;
    n_checks++;
    if ({Done, Done_Id, Result} !== {1'b1, 1'b1, 4'b0101}) begin
      n_fail++;
      $display("FAIL pending_done got done=%b id=%b res=%b exp 1 1 0101", Done, Done_Id, Result);
    end
    tick;
  endtask

  task automatic test_reset_mid_load;
    logic seen_done;
    Word0 = 4'b1011;
    Dir = 2'b01;
    Req = 2'b01;
    tick;
    Req = 2'b00;
    tick;
    tick;
    n_checks++;
    if ({Reg_Ena, Busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_load_active got ena=%b busy=%b exp 1 1", Reg_Ena, Busy);
    end
    Rst = 1'b0;
    #1;
    n_checks++;
    if ({Gnt, Busy, Done, Done_Id, Result, Reg_Data_In, Reg_Ena, Reg_LeRi, q} !== 15'b0) begin
      n_fail++;
      $display("FAIL mid_load_reset got %b exp 0", {Gnt, Busy, Done, Done_Id, Result, Reg_Data_In, Reg_Ena, Reg_LeRi, q});
    end
    tick;
    Rst = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick;
      seen_done = seen_done | Done | Reg_Ena;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL aborted_no_done got activity=%b exp 0", seen_done);
    end
    Word1 = 4'b0011;
    Dir = 2'b00;
    Req = 2'b10;
    tick;
    Req = 2'b00;
    n_checks++;
    if (Gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_grant got %b exp 10", Gnt);
    end
    for (int k = 0; k < 8; k++) tick;
    n_checks++;
    if ({Done, Done_Id, Result} !== {1'b1, 1'b1, 4'b0011}) begin
      n_fail++;
      $display("FAIL post_reset_done got done=%b id=%b res=%b exp 1 1 0011", Done, Done_Id, Result);
    end
  endtask

  initial begin
    test_reset;
    test_single(1'b0, 1'b1, 4'b1011, 4'b1011);
    test_single(1'b1, 1'b0, 4'b0110, 4'b0110);
    test_contention;
    tick;
    test_back_to_back;
    test_reset_mid_load;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
